// File: rtl/adc_meas_pkg.sv
// -----------------------------------------------------------------------------
// adc_meas_pkg
// Shared definitions for the ADC wave meter: FSM state encoding and the
// default widths and Schmitt-trigger levels.
// -----------------------------------------------------------------------------
package adc_meas_pkg;

    localparam int DATA_W_D = 8;     // ADC sample width
    localparam int CNT_W_D  = 32;    // gate / clock / edge counter width
    localparam int MID_D    = 128;   // crossing mid-level
    localparam int HYST_D   = 8;     // hysteresis half-width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/schmitt_edge_det.sv
// -----------------------------------------------------------------------------
// schmitt_edge_det
// Registers the ADC sample, applies a hysteresis (Schmitt) level detector and
// emits a one-cycle pulse on each low-to-high level transition.
// Pin-to-rise latency is 2 cycles (ad_q register + level/pulse register).
//
// Optional macro ADC_AVG_EN: a 4-tap moving average of ad_q feeds the
// detector and the sample output, adding 1 cycle (latency 3). The history
// clears on i_clr.
//
// Ports:
//   i_clk    in   clock
//   i_rst_n  in   async active-low reset
//   i_clr    in   clear averager history (unused without ADC_AVG_EN)
//   i_data   in   raw ADC sample
//   o_samp   out  conditioned sample (ad_q or average) for min/max tracking
//   o_rise   out  one-cycle rising-crossing pulse
// -----------------------------------------------------------------------------
module schmitt_edge_det #(
    parameter int DATA_W = 8,
    parameter int MID    = 128,
    parameter int HYST   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_samp,
    output logic              o_rise
);

    // Thresholds clamped to the representable sample range.
    localparam int DMAX = (1 << DATA_W) - 1;
    localparam int HI_I = (MID + HYST > DMAX) ? DMAX : MID + HYST;
    localparam int LO_I = (MID < HYST) ? 0 : MID - HYST;
    localparam logic [DATA_W-1:0] TH_HI = HI_I[DATA_W-1:0];
    localparam logic [DATA_W-1:0] TH_LO = LO_I[DATA_W-1:0];

    logic [DATA_W-1:0] r_ad_q;
    logic [DATA_W-1:0] w_samp;
    logic              r_lvl;
    logic              r_rise;
    logic              w_lvl_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_ad_q <= '0;
        else          r_ad_q <= i_data;
    end

`ifdef ADC_AVG_EN
    logic [DATA_W-1:0] r_h0, r_h1, r_h2, r_avg;
    logic [DATA_W+1:0] w_sum;

    assign w_sum = {2'b00, r_ad_q} + {2'b00, r_h0} + {2'b00, r_h1} + {2'b00, r_h2};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h0  <= '0;
            r_h1  <= '0;
            r_h2  <= '0;
            r_avg <= '0;
        end else begin
            r_avg <= w_sum[DATA_W+1:2];
            if (i_clr) begin
                r_h0 <= '0;
                r_h1 <= '0;
                r_h2 <= '0;
            end else begin
                r_h0 <= r_ad_q;
                r_h1 <= r_h0;
                r_h2 <= r_h1;
            end
        end
    end

    assign w_samp = r_avg;
`else
    logic w_unused_clr;
    assign w_unused_clr = i_clr;
    assign w_samp       = r_ad_q;
`endif

    // Between the thresholds the level holds its previous value.
    always_comb begin
        w_lvl_nxt = r_lvl;
        if (w_samp >= TH_HI)      w_lvl_nxt = 1'b1;
        else if (w_samp <= TH_LO) w_lvl_nxt = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lvl  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_lvl  <= w_lvl_nxt;
            r_rise <= w_lvl_nxt & ~r_lvl;
        end
    end

    assign o_samp = w_samp;
    assign o_rise = r_rise;

endmodule

// File: rtl/adc_wave_meter.sv
// -----------------------------------------------------------------------------
// adc_wave_meter
// Gated ADC waveform meter. Over a programmed gate window it counts whole
// periods (rising Schmitt crossings after the first), the clock span between
// the first and last counted crossing, and min/max sample levels.
// Frequency = f_clk * edge_cnt / clk_cnt.
//
// Optional macro ADC_AVG_EN: 4-tap moving average ahead of the detector
// (see schmitt_edge_det).
//
// Ports:
//   Clk, Rst_n        clock, async active-low reset
//   AD_Clk            ADC sample clock (= Clk)
//   AD_Data           ADC sample
//   gate_len_in       gate length in Clk cycles, latched on start
//   meas_start_pulse  one-cycle start request (ignored while busy)
//   busy              high ARM..DONE
//   meas_done         one-cycle result-valid pulse (DONE state)
//   edge_cnt          whole periods counted
//   clk_cnt           cycles between first and last counted rising crossing
//   vmax, vmin        sample extremes over the gate
//   timeout           no full period inside the gate
// -----------------------------------------------------------------------------
module adc_wave_meter
    import adc_meas_pkg::*;
#(
    parameter int DATA_W = DATA_W_D,
    parameter int CNT_W  = CNT_W_D,
    parameter int MID    = MID_D,
    parameter int HYST   = HYST_D
) (
    input  logic              Clk,
    input  logic              Rst_n,
    output logic              AD_Clk,
    input  logic [DATA_W-1:0] AD_Data,
    input  logic [CNT_W-1:0]  gate_len_in,
    input  logic              meas_start_pulse,
    output logic              busy,
    output logic              meas_done,
    output logic [CNT_W-1:0]  edge_cnt,
    output logic [CNT_W-1:0]  clk_cnt,
    output logic [DATA_W-1:0] vmax,
    output logic [DATA_W-1:0] vmin,
    output logic              timeout
);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_gate_work, w_gate_work_nxt;
    logic [CNT_W-1:0]  r_gate_cnt,  w_gate_cnt_nxt;
    logic [CNT_W-1:0]  r_span_cnt,  w_span_cnt_nxt;
    logic [CNT_W-1:0]  r_edges_w,   w_edges_nxt;
    logic [CNT_W-1:0]  r_last_span, w_last_nxt;
    logic [DATA_W-1:0] r_vmax_w,    w_vmax_nxt;
    logic [DATA_W-1:0] r_vmin_w,    w_vmin_nxt;
    logic              w_clr;
    logic [DATA_W-1:0] w_samp;
    logic              w_rise;
    logic              w_expire;

    logic [CNT_W-1:0]  r_edge_cnt, r_clk_cnt;
    logic [DATA_W-1:0] r_vmax, r_vmin;
    logic              r_timeout;

    assign AD_Clk = Clk;

    schmitt_edge_det #(
        .DATA_W (DATA_W),
        .MID    (MID),
        .HYST   (HYST)
    ) u_det (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_clr   (w_clr),
        .i_data  (AD_Data),
        .o_samp  (w_samp),
        .o_rise  (w_rise)
    );

    assign w_expire = (r_gate_cnt == r_gate_work);

    always_comb begin
        w_state_nxt     = r_state;
        w_gate_work_nxt = r_gate_work;
        w_gate_cnt_nxt  = r_gate_cnt;
        w_span_cnt_nxt  = r_span_cnt;
        w_edges_nxt     = r_edges_w;
        w_last_nxt      = r_last_span;
        w_vmax_nxt      = r_vmax_w;
        w_vmin_nxt      = r_vmin_w;
        w_clr           = 1'b0;

        // Extremes follow the sample during the whole gate window.
        if (r_state == S_ARM || r_state == S_MEAS) begin
            if (w_samp > r_vmax_w) w_vmax_nxt = w_samp;
            if (w_samp < r_vmin_w) w_vmin_nxt = w_samp;
        end

        case (r_state)
            S_IDLE: begin
                if (meas_start_pulse) begin
                    w_gate_work_nxt = gate_len_in;
                    w_gate_cnt_nxt  = CNT_W'(1);
                    w_span_cnt_nxt  = '0;
                    w_edges_nxt     = '0;
                    w_last_nxt      = '0;
                    w_vmax_nxt      = '0;
                    w_vmin_nxt      = '1;
                    w_clr           = 1'b1;
                    w_state_nxt     = (gate_len_in == '0) ? S_DONE : S_ARM;
                end
            end
            S_ARM: begin
                w_gate_cnt_nxt = r_gate_cnt + CNT_W'(1);
                // First crossing only opens the span; it is not a period.
                if (w_rise) begin
                    w_span_cnt_nxt = '0;
                    w_state_nxt    = S_MEAS;
                end
                if (w_expire) w_state_nxt = S_DONE;
            end
            S_MEAS: begin
                w_gate_cnt_nxt = r_gate_cnt + CNT_W'(1);
                w_span_cnt_nxt = r_span_cnt + CNT_W'(1);
                if (w_rise) begin
                    if (r_edges_w != '1) w_edges_nxt = r_edges_w + CNT_W'(1);
                    w_last_nxt = r_span_cnt + CNT_W'(1);
                end
                if (w_expire) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_gate_work <= '0;
            r_gate_cnt  <= '0;
            r_span_cnt  <= '0;
            r_edges_w   <= '0;
            r_last_span <= '0;
            r_vmax_w    <= '0;
            r_vmin_w    <= '1;
        end else begin
            r_state     <= w_state_nxt;
            r_gate_work <= w_gate_work_nxt;
            r_gate_cnt  <= w_gate_cnt_nxt;
            r_span_cnt  <= w_span_cnt_nxt;
            r_edges_w   <= w_edges_nxt;
            r_last_span <= w_last_nxt;
            r_vmax_w    <= w_vmax_nxt;
            r_vmin_w    <= w_vmin_nxt;
        end
    end

    // Results are captured from the next-state working values on DONE entry,
    // so a crossing on the final gate cycle is included and the outputs are
    // already valid while meas_done is high.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_edge_cnt <= '0;
            r_clk_cnt  <= '0;
            r_vmax     <= '0;
            r_vmin     <= '1;
            r_timeout  <= 1'b0;
        end else if (w_state_nxt == S_DONE && r_state != S_DONE) begin
            r_edge_cnt <= w_edges_nxt;
            r_clk_cnt  <= w_last_nxt;
            r_vmax     <= w_vmax_nxt;
            r_vmin     <= w_vmin_nxt;
            r_timeout  <= (w_edges_nxt == '0);
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign meas_done = (r_state == S_DONE);
    assign edge_cnt  = r_edge_cnt;
    assign clk_cnt   = r_clk_cnt;
    assign vmax      = r_vmax;
    assign vmin      = r_vmin;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_adc_wave_meter.sv
// -----------------------------------------------------------------------------
// tb_adc_wave_meter
// Directed bench for adc_wave_meter: square, in-hysteresis, triangle, zero
// gate, start-while-busy and mid-gate reset cases with hand-derived results.
// Waveform phase ph = k is the value sampled on the k-th edge after start
// (k = 0 is the start edge); a pin sample at phase k produces rise_evt in
// gate cycle k+2.
// -----------------------------------------------------------------------------
module tb_adc_wave_meter;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        AD_Clk;
    logic [7:0]  AD_Data;
    logic [31:0] gate_len_in;
    logic        meas_start_pulse;
    logic        busy, meas_done, timeout;
    logic [31:0] edge_cnt, clk_cnt;
    logic [7:0]  vmax, vmin;

    int nvec = 0;
    int nerr = 0;
    int mode = 0;
    int ph   = 0;
    int n;
    int pulses;

    always #5 Clk = ~Clk;

    adc_wave_meter dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .AD_Clk           (AD_Clk),
        .AD_Data          (AD_Data),
        .gate_len_in      (gate_len_in),
        .meas_start_pulse (meas_start_pulse),
        .busy             (busy),
        .meas_done        (meas_done),
        .edge_cnt         (edge_cnt),
        .clk_cnt          (clk_cnt),
        .vmax             (vmax),
        .vmin             (vmin),
        .timeout          (timeout)
    );

    // 1: square 0/255 period 100, high for phases 48..97 (rises in gate 50,150..)
    // 2: 124/132 alternating, inside the 120..136 hysteresis band
    // 3: triangle 20..230 period 64, first sample >= 136 at phase 18
    function automatic logic [7:0] wave(input int m, input int p);
        int q;
        case (m)
            1: return (((p + 52) % 100) < 50) ? 8'd255 : 8'd0;
            2: return (p % 2 != 0) ? 8'd132 : 8'd124;
            3: begin
                q = p % 64;
                if (q <= 32) return 8'(20 + (q * 210) / 32);
                else         return 8'(20 + ((64 - q) * 210) / 32);
            end
            default: return 8'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
        ph++;
        AD_Data = wave(mode, ph);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int cyc);
        mode = 0;
        AD_Data = 8'd0;
        repeat (cyc) tick();
    endtask

    task automatic start(input logic [31:0] len, input int m);
        mode = m;
        ph = 0;
        AD_Data = wave(m, 0);
        gate_len_in = len;
        meas_start_pulse = 1'b1;
        tick();
        meas_start_pulse = 1'b0;
    endtask

    // Ticks until meas_done; optionally fires a short-gate start at tick inj.
    task automatic wait_done(input int budget, input int inj, output int cnt);
        cnt = 0;
        while (meas_done !== 1'b1 && cnt < budget) begin
            if (cnt == inj) begin
                gate_len_in = 32'd5;
                meas_start_pulse = 1'b1;
            end
            tick();
            meas_start_pulse = 1'b0;
            cnt++;
        end
    endtask

    task automatic chk_res(input string tag, input logic [31:0] e_edge, input logic [31:0] e_clk,
                           input logic [7:0] e_max, input logic [7:0] e_min, input logic e_to);
        chk({tag, "_done"},  32'(meas_done), 32'd1);
        chk({tag, "_busy"},  32'(busy),      32'd1);
        chk({tag, "_edge"},  edge_cnt,       e_edge);
        chk({tag, "_clk"},   clk_cnt,        e_clk);
        chk({tag, "_vmax"},  32'(vmax),      32'(e_max));
        chk({tag, "_vmin"},  32'(vmin),      32'(e_min));
        chk({tag, "_to"},    32'(timeout),   32'(e_to));
        tick();
        chk({tag, "_done_pulse"}, 32'(meas_done), 32'd0);
        chk({tag, "_idle"},       32'(busy),      32'd0);
    endtask

    initial begin
        Rst_n = 1'b0;
        AD_Data = 8'd0;
        gate_len_in = 32'd0;
        meas_start_pulse = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(meas_done), 32'd0);
        chk("rst_to",   32'(timeout), 32'd0);
        chk("rst_edge", edge_cnt, 32'd0);
        chk("rst_clk",  clk_cnt, 32'd0);
        chk("rst_vmax", 32'(vmax), 32'd0);
        chk("rst_vmin", 32'(vmin), 32'd255);
        Rst_n = 1'b1;
        idle(4);

        // Square: rises in gate cycles 50,150..950 -> 9 periods over 900 cycles.
        start(32'd1000, 1);
        wait_done(1100, -1, n);
        chk("sq_latency", 32'(n), 32'd1000);
        chk_res("sq", 32'd9, 32'd900, 8'd255, 8'd0, 1'b0);
        idle(3);
        chk("sq_hold_edge", edge_cnt, 32'd9);

        // In-band toggling never crosses a threshold.
        start(32'd500, 2);
        wait_done(600, -1, n);
        chk("hy_latency", 32'(n), 32'd500);
        chk_res("hy", 32'd0, 32'd0, 8'd132, 8'd124, 1'b1);
        idle(4);

        // Triangle: rises in gate cycles 20,84..596 -> 9 periods, 576 cycles.
        start(32'd640, 3);
        wait_done(700, -1, n);
        chk("tri_latency", 32'(n), 32'd640);
        chk_res("tri", 32'd9, 32'd576, 8'd230, 8'd20, 1'b0);
        idle(2);

        // Zero gate: DONE immediately after the start edge.
        start(32'd0, 0);
        chk_res("zero", 32'd0, 32'd0, 8'd0, 8'd255, 1'b1);
        idle(4);

        // Start request while busy must not shorten the gate.
        start(32'd1000, 1);
        wait_done(1100, 200, n);
        chk("busy_latency", 32'(n), 32'd1000);
        chk_res("busy", 32'd9, 32'd900, 8'd255, 8'd0, 1'b0);
        idle(4);

        // Reset mid-gate aborts without a done pulse.
        start(32'd1000, 1);
        repeat (299) tick();
        Rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(meas_done), 32'd0);
        chk("abort_edge", edge_cnt, 32'd0);
        chk("abort_clk",  clk_cnt, 32'd0);
        chk("abort_vmax", 32'(vmax), 32'd0);
        chk("abort_vmin", 32'(vmin), 32'd255);
        chk("abort_to",   32'(timeout), 32'd0);
        repeat (3) tick();
        Rst_n = 1'b1;
        pulses = 0;
        repeat (1000) begin
            tick();
            if (meas_done === 1'b1) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        idle(4);
        start(32'd1000, 1);
        wait_done(1100, -1, n);
        chk("re_latency", 32'(n), 32'd1000);
        chk_res("re", 32'd9, 32'd900, 8'd255, 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
